imem_slv: RTL
=============

IMEM_SLV -- requirements
Module: imem_slv

Interface
REQ-001 SHALL have parameter AW, default 32, meaning address width.
REQ-002 SHALL have parameter DW, default 32, meaning instruction width.
REQ-003 SHALL have parameter DEPTH, default 1024, meaning number of DW-bit words in the array.
REQ-004 SHALL have parameter LAT, default 1, legal range 1..15, meaning cycles from request handshake to rsp_vld.
REQ-005 SHALL have parameter BASE, default 32'h0, meaning byte address of word 0.
REQ-006 SHALL have port clk, input, 1, clock; all logic on rising edge.
REQ-007 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-008 SHALL have port ifetch, ifetch_if_t.slave: req_vld in 1; req_rdy out 1; req_pc in AW; rsp_vld out 1; rsp_rdy in 1; rsp_ir out DW.
REQ-009 SHALL have port ld_vld, input, 1, program-load write strobe.
REQ-010 SHALL have port ld_addr, input, $clog2(DEPTH), program-load word index.
REQ-011 SHALL have port ld_data, input, DW, program-load word.
REQ-012 SHALL have port err, output, 1, sticky bad-fetch flag.
REQ-013 SHALL have port fetch_cnt, output, 32, count of completed response handshakes.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, RESP; one request outstanding at most.
REQ-015 SHALL drive req_rdy = (state==IDLE) | (state==RESP & rsp_rdy); req_rdy SHALL be 0 in BUSY.
REQ-016 On request handshake SHALL latch req_pc and load a down-counter with LAT-1; next state BUSY if LAT>1, else RESP.
REQ-017 In BUSY SHALL decrement the counter each cycle and go to RESP in the cycle after it reaches 0; rsp_vld SHALL rise exactly LAT cycles after the request handshake cycle.
REQ-018 SHALL register rsp_ir on the clock edge entering RESP; rsp_ir and rsp_vld SHALL stay stable in RESP until rsp_rdy.
REQ-019 On response handshake with req_vld=1 SHALL accept the new request in the same cycle (back-to-back); with LAT=1 this gives one instruction per cycle.
REQ-020 On response handshake with req_vld=0 SHALL return to IDLE.
REQ-021 Word index SHALL be (pc - BASE) >> 2, computed in AW bits.
REQ-022 If pc[1:0]!=0, pc<BASE, or index>=DEPTH, SHALL return IMEM_NOP (32'h0000_0013) and set err at the RESP entry edge.
REQ-023 err SHALL clear only on reset.
REQ-024 ld_vld SHALL write ld_data to ld_addr in one cycle.
REQ-025 ld_addr>=DEPTH SHALL be ignored and SHALL NOT set err.
REQ-026 Write and read to the same index in the same cycle SHALL return old data (read-first).
REQ-027 fetch_cnt SHALL increment by 1 per response handshake and wrap from 32'hFFFF_FFFF to 0.
REQ-028 req_vld while req_rdy=0 SHALL be ignored; no request is queued.

Reset
REQ-029 Reset SHALL force state IDLE, counter 0, rsp_vld 0, rsp_ir 0, err 0, fetch_cnt 0, latched pc 0.
REQ-030 req_rdy SHALL read 1 during and after reset.
REQ-031 Reset mid-operation (BUSY or RESP) SHALL drop the pending request without producing a response.
REQ-032 Array contents SHALL NOT be reset.

Structure
REQ-033 Shared package imem_pkg SHALL hold IMEM_NOP and the state enum imem_state_e.
REQ-034 Storage SHALL be a sub-module imem_array: 1 write port, 1 synchronous read port, read-first.
REQ-035 FSM, counter, address check, err and fetch_cnt SHALL reside in imem_slv.

Verification
REQ-036 LAT=1: load words 0..3 = 0x11,0x22,0x33,0x44; hold req_vld=1, rsp_rdy=1 with pc 0,4,8,12 -> rsp_ir 0x11..0x44 on 4 consecutive cycles; fetch_cnt=4.
REQ-037 LAT=3: request pc 4 -> rsp_vld rises exactly 3 cycles after the handshake; req_rdy=0 for 2 cycles.
REQ-038 rsp_rdy=0 for 5 cycles in RESP -> rsp_vld and rsp_ir stable; req_rdy=0; no new request accepted.
REQ-039 pc=0x2 and pc=BASE+4*DEPTH -> rsp_ir=0x0000_0013; err=1 and stays 1 through later good fetches.
REQ-040 rst_n pulse while BUSY -> rsp_vld never rises; err=0; fetch_cnt=0; req_rdy=1.
REQ-041 ld_vld to index 2 in the RESP-entry cycle of a pc=8 fetch -> old data returned; next fetch of pc=8 returns new data.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared constants and types for the instruction-memory slave.
package imem_pkg;

    localparam logic [31:0] IMEM_NOP = 32'h0000_0013;
    localparam int unsigned CNT_W    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } imem_state_e;

endpackage

// File: rtl/ifetch_if_t.sv
// Instruction-fetch request/response handshake bundle.
interface ifetch_if_t #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          req_vld;
    logic          req_rdy;
    logic [AW-1:0] req_pc;
    logic          rsp_vld;
    logic          rsp_rdy;
    logic [DW-1:0] rsp_ir;

    modport master (
        output req_vld, req_pc, rsp_rdy,
        input  req_rdy, rsp_vld, rsp_ir
    );

    modport slave (
        input  req_vld, req_pc, rsp_rdy,
        output req_rdy, rsp_vld, rsp_ir
    );
endinterface

// File: rtl/imem_array.sv
// Instruction storage: one write port, one registered read-first read port.
module imem_array
    import imem_pkg::*;
#(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DW-1:0]            wdata,
    input  logic                     re,
    input  logic                     rd_nop,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DW-1:0]            rdata
);
    localparam int unsigned IW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic          wr_ok;

    // Out-of-range load indices are dropped silently.
    assign wr_ok = we && ({1'b0, waddr} < (IW+1)'(DEPTH));

    always_ff @(posedge clk) begin : wr_port
        if (wr_ok) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register only; a same-cycle write lands after this read samples.
    always_ff @(posedge clk or negedge rst_n) begin : rd_port
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= rd_nop ? DW'(IMEM_NOP) : mem[raddr];
        end
    end

endmodule

// File: rtl/imem_slv.sv
// Instruction-memory slave: fixed-latency fetch with bad-address trap and load port.
module imem_slv
    import imem_pkg::*;
#(
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned LAT   = 1,
    parameter logic [31:0] BASE  = 32'h0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    ifetch_if_t.slave                ifetch,
    input  logic                     ld_vld,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [DW-1:0]            ld_data,
    output logic                     err,
    output logic [31:0]              fetch_cnt
);
    localparam int unsigned IW     = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LAT - 1);
    localparam bit          SINGLE = (LAT == 1);

    imem_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [AW-1:0]    pc_q;
    logic             rsp_vld_q;
    logic             err_q;
    logic [31:0]      fetch_cnt_q;
    logic [DW-1:0]    rsp_ir_q;

    logic             req_rdy_c;
    logic             req_fire;
    logic             rsp_fire;
    logic             enter_resp;

    logic [AW-1:0]    rd_pc;
    logic [AW-1:0]    off;
    logic [AW-1:0]    idx;
    logic             under;
    logic             bad;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin : state_reg
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin : next_state
        state_d = state_q;
        unique case (state_q)
            IDLE: if (ifetch.req_vld) state_d = SINGLE ? RESP : BUSY;
            BUSY: if (cnt_q == CNT_W'(1)) state_d = RESP;
            RESP: if (ifetch.rsp_rdy) begin
                state_d = ifetch.req_vld ? (SINGLE ? RESP : BUSY) : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake decode; RESP entry is the read/check strobe.
    always_comb begin : out_comb
        req_rdy_c  = 1'b0;
        rsp_fire   = 1'b0;
        req_fire   = 1'b0;
        enter_resp = 1'b0;
        req_rdy_c  = (state_q == IDLE) || ((state_q == RESP) && ifetch.rsp_rdy);
        rsp_fire   = (state_q == RESP) && ifetch.rsp_rdy;
        req_fire   = req_rdy_c && ifetch.req_vld;
        enter_resp = (req_fire && SINGLE) || ((state_q == BUSY) && (cnt_q == CNT_W'(1)));
    end

    // With LAT=1 the read happens on the handshake edge, so use the live pc.
    always_comb begin : addr_check
        rd_pc        = (state_q == BUSY) ? pc_q : ifetch.req_pc;
        {under, off} = {1'b0, rd_pc} - {1'b0, AW'(BASE)};
        idx          = off >> 2;
        bad          = (rd_pc[1:0] != 2'b00) || under || (idx >= AW'(DEPTH));
    end

    // Latency counter, latched pc, response valid, sticky error, handshake count.
    always_ff @(posedge clk or negedge rst_n) begin : ctrl_ff
        if (!rst_n) begin
            cnt_q       <= '0;
            pc_q        <= '0;
            rsp_vld_q   <= 1'b0;
            err_q       <= 1'b0;
            fetch_cnt_q <= '0;
        end else begin
            if (req_fire) begin
                cnt_q <= LAT_M1;
                pc_q  <= ifetch.req_pc;
            end else if (state_q == BUSY) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            rsp_vld_q <= (state_d == RESP);
            if (enter_resp && bad) begin
                err_q <= 1'b1;
            end
            if (rsp_fire) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
        end
    end

    imem_array #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_array (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (ld_vld),
        .waddr  (ld_addr),
        .wdata  (ld_data),
        .re     (enter_resp),
        .rd_nop (bad),
        .raddr  (idx[IW-1:0]),
        .rdata  (rsp_ir_q)
    );

    assign ifetch.req_rdy = req_rdy_c;
    assign ifetch.rsp_vld = rsp_vld_q;
    assign ifetch.rsp_ir  = rsp_ir_q;
    assign err            = err_q;
    assign fetch_cnt      = fetch_cnt_q;

endmodule
